// File: rtl/mix_stream_pipe.sv
// Flow-controlled mixing stage: y_n = (s_n + OFFSET) ^ s_(n-DEPTH), with a
// one-entry registered valid/ready output and a count of completed transfers.
module mix_stream_pipe #(
    parameter int                WIDTH  = 8,
    parameter int                DEPTH  = 2,
    parameter logic [WIDTH-1:0]  OFFSET = WIDTH'(8'h22),
    parameter logic [WIDTH-1:0]  SEED   = WIDTH'(8'h03),
    parameter int                CNT_W  = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    logic [WIDTH-1:0] hist [DEPTH];
    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;

    // A full output register can only take a new sample if it drains in the same cycle.
    assign in_ready = ~flush & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign transfer = out_valid & out_ready;
    assign sum      = in_data + OFFSET;
    assign result   = sum ^ hist[DEPTH-1];

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= SEED;
            end
        end else if (flush) begin
            // A pending result is discarded and does not count as a transfer.
            out_valid <= 1'b0;
            out_count <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= SEED;
            end
        end else begin
            if (transfer) begin
                out_count <= out_count + CNT_W'(1);
            end
            if (accept) begin
                out_data  <= result;
                out_valid <= 1'b1;
                hist[0]   <= in_data;
                for (int k = 1; k < DEPTH; k++) begin
                    hist[k] <= hist[k-1];
                end
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
